// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_pkg
// Description : Shared state encoding, master indices and address decode for
//               the AXI read scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic M0_IDX = 1'b0;
    localparam logic M1_IDX = 1'b1;

    // Only the low 128 KiB window is decoded; bit 16 picks the slave inside it.
    localparam logic [31:0] DEC_MASK    = 32'hFFFE_0000;
    localparam int unsigned SLV_SEL_BIT = 16;

    function automatic logic addr_in_range(input logic [31:0] addr);
        return (addr & DEC_MASK) == 32'h0;
    endfunction

    function automatic logic [1:0] slv_onehot(input logic sel_bit);
        return sel_bit ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_rd_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_sched_if
// Description : Read-channel signals of two masters and two slaves as seen by
//               the scheduler. master drives the fabric, slave observes it.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_rd_sched_if;
    logic        ARVALID_M0;
    logic [31:0] ARADDR_M0;
    logic        ARVALID_M1;
    logic [31:0] ARADDR_M1;
    logic        ARREADY_S0;
    logic        ARREADY_S1;
    logic        RVALID_S0;
    logic        RVALID_S1;
    logic        RLAST_S0;
    logic        RLAST_S1;
    logic        RREADY_M0;
    logic        RREADY_M1;

    modport master (
        output ARVALID_M0, ARADDR_M0, ARVALID_M1, ARADDR_M1,
               ARREADY_S0, ARREADY_S1, RVALID_S0, RVALID_S1,
               RLAST_S0, RLAST_S1, RREADY_M0, RREADY_M1
    );

    modport slave (
        input  ARVALID_M0, ARADDR_M0, ARVALID_M1, ARADDR_M1,
               ARREADY_S0, ARREADY_S1, RVALID_S0, RVALID_S1,
               RLAST_S0, RLAST_S1, RREADY_M0, RREADY_M1
    );
endinterface
`default_nettype wire

// File: rtl/axi_rd_sched_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin pick; on a tie the master that was
//               not granted last wins. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import axi_pkg::*;
(
    input  wire [1:0] i_req,
    input  wire       i_last,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = (i_last == M1_IDX) ? 2'b01 : 2'b10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_rd_sched.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_sched
// Description : Round-robin read scheduler for two AXI masters and two slaves.
//               Optional data-phase watchdog enabled by macro AXI_RD_WDT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_sched
    import axi_pkg::*;
#(
    parameter logic [7:0] WDT_LIMIT = 8'd255
)(
    input  wire              ACLK,
    input  wire              ARESETn,
    axi_rd_sched_if.slave    bus,
    output logic [1:0]       GRANT,
    output logic [1:0]       SLV_SEL,
    output logic             AR_PHASE,
    output logic             BUSY,
    output logic [1:0]       DEC_ERR,
    output logic             WDT_TIMEOUT
);

    logic [1:0] state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] slv_q, slv_d;
    logic [1:0] dec_err_q, dec_err_d;
    logic       last_q, last_d;
    logic       wdt_to_q, wdt_to_d;
`ifdef AXI_RD_WDT_EN
    logic [7:0] wdt_cnt_q, wdt_cnt_d;
`endif

    logic [1:0] w_req;
    logic [1:0] w_pick;
    logic [1:0] w_pick_slv;
    logic       w_arb_last;
    logic       w_g_idx;
    logic       w_g_arvalid, w_g_rready;
    logic       w_s_arready, w_s_rvalid, w_s_rlast;
    logic       w_final_beat;
    logic       w_unused;

    assign w_req = {bus.ARVALID_M1 && addr_in_range(bus.ARADDR_M1),
                    bus.ARVALID_M0 && addr_in_range(bus.ARADDR_M0)};

    assign w_g_idx     = grant_q[1] ? M1_IDX : M0_IDX;
    assign w_g_arvalid = w_g_idx ? bus.ARVALID_M1 : bus.ARVALID_M0;
    assign w_g_rready  = w_g_idx ? bus.RREADY_M1  : bus.RREADY_M0;
    assign w_s_arready = slv_q[1] ? bus.ARREADY_S1 : bus.ARREADY_S0;
    assign w_s_rvalid  = slv_q[1] ? bus.RVALID_S1  : bus.RVALID_S0;
    assign w_s_rlast   = slv_q[1] ? bus.RLAST_S1   : bus.RLAST_S0;
    assign w_final_beat = w_s_rvalid && w_g_rready && w_s_rlast;

    // On the completing beat the pointer already counts the finishing master.
    assign w_arb_last = (state_q == ST_DATA) ? w_g_idx : last_q;

    rr_arb2 u_arb (
        .i_req  (w_req),
        .i_last (w_arb_last),
        .o_gnt  (w_pick)
    );

    assign w_pick_slv = w_pick[0] ? slv_onehot(bus.ARADDR_M0[SLV_SEL_BIT])
                                  : slv_onehot(bus.ARADDR_M1[SLV_SEL_BIT]);

    assign w_unused = ^{bus.ARADDR_M0[15:0], bus.ARADDR_M1[15:0], WDT_LIMIT};

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        slv_d     = slv_q;
        last_d    = last_q;
        wdt_to_d  = 1'b0;
        dec_err_d = {bus.ARVALID_M1 && !addr_in_range(bus.ARADDR_M1),
                     bus.ARVALID_M0 && !addr_in_range(bus.ARADDR_M0)};
`ifdef AXI_RD_WDT_EN
        wdt_cnt_d = wdt_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|w_req) begin
                    state_d = ST_ADDR;
                    grant_d = w_pick;
                    slv_d   = w_pick_slv;
                end
            end
            ST_ADDR: begin
                if (!w_g_arvalid) begin
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                    slv_d   = 2'b00;
                end else if (w_s_arready) begin
                    state_d = ST_DATA;
`ifdef AXI_RD_WDT_EN
                    wdt_cnt_d = 8'd0;
`endif
                end
            end
            ST_DATA: begin
                if (w_final_beat) begin
                    last_d = w_g_idx;
                    if (|w_req) begin
                        state_d = ST_ADDR;
                        grant_d = w_pick;
                        slv_d   = w_pick_slv;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = 2'b00;
                        slv_d   = 2'b00;
                    end
                end
`ifdef AXI_RD_WDT_EN
                else if (wdt_cnt_q == WDT_LIMIT) begin
                    state_d  = ST_IDLE;
                    grant_d  = 2'b00;
                    slv_d    = 2'b00;
                    last_d   = w_g_idx;
                    wdt_to_d = 1'b1;
                end else begin
                    wdt_cnt_d = wdt_cnt_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
                slv_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= ST_IDLE;
            grant_q   <= 2'b00;
            slv_q     <= 2'b00;
            dec_err_q <= 2'b00;
            last_q    <= M1_IDX;
            wdt_to_q  <= 1'b0;
`ifdef AXI_RD_WDT_EN
            wdt_cnt_q <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            slv_q     <= slv_d;
            dec_err_q <= dec_err_d;
            last_q    <= last_d;
            wdt_to_q  <= wdt_to_d;
`ifdef AXI_RD_WDT_EN
            wdt_cnt_q <= wdt_cnt_d;
`endif
        end
    end

    assign GRANT       = grant_q;
    assign SLV_SEL     = slv_q;
    assign AR_PHASE    = (state_q == ST_ADDR);
    assign BUSY        = (state_q != ST_IDLE);
    assign DEC_ERR     = dec_err_q;
    assign WDT_TIMEOUT = wdt_to_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_rd_sched
// Description : Directed self-checking bench for axi_rd_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rd_sched;

    logic       clk;
    logic       rst_n;
    logic [1:0] grant, slv_sel, dec_err;
    logic       ar_phase, busy, wdt_timeout;
    int         n_cmp;
    int         n_err;

    axi_rd_sched_if bus ();

    axi_rd_sched #(.WDT_LIMIT(8'd10)) dut (
        .ACLK        (clk),
        .ARESETn     (rst_n),
        .bus         (bus),
        .GRANT       (grant),
        .SLV_SEL     (slv_sel),
        .AR_PHASE    (ar_phase),
        .BUSY        (busy),
        .DEC_ERR     (dec_err),
        .WDT_TIMEOUT (wdt_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ARVALID_M0 = 1'b0; bus.ARADDR_M0 = 32'h0;
        bus.ARVALID_M1 = 1'b0; bus.ARADDR_M1 = 32'h0;
        bus.ARREADY_S0 = 1'b0; bus.ARREADY_S1 = 1'b0;
        bus.RVALID_S0  = 1'b0; bus.RVALID_S1  = 1'b0;
        bus.RLAST_S0   = 1'b0; bus.RLAST_S1   = 1'b0;
        bus.RREADY_M0  = 1'b0; bus.RREADY_M1  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // M0 read of S0 at 0x1000 from IDLE through to completion.
    task automatic m0_full_read();
        bus.ARVALID_M0 = 1'b1; bus.ARADDR_M0 = 32'h0000_1000;
        step();
        bus.ARREADY_S0 = 1'b1;
        step();
        bus.ARVALID_M0 = 1'b0; bus.ARREADY_S0 = 1'b0;
        bus.RVALID_S0 = 1'b1; bus.RLAST_S0 = 1'b1; bus.RREADY_M0 = 1'b1;
        step();
        clear_inputs();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (grant !== 2'b00)   begin n_err++; $display("FAIL reset_grant got=%b exp=00", grant); end
        n_cmp++; if (slv_sel !== 2'b00) begin n_err++; $display("FAIL reset_slv got=%b exp=00", slv_sel); end
        n_cmp++; if ({ar_phase, busy, wdt_timeout} !== 3'b000)
            begin n_err++; $display("FAIL reset_flags got=%b exp=000", {ar_phase, busy, wdt_timeout}); end
        n_cmp++; if (dec_err !== 2'b00) begin n_err++; $display("FAIL reset_decerr got=%b exp=00", dec_err); end
    endtask

    task automatic test_single_grant();
        do_reset();
        bus.ARVALID_M0 = 1'b1; bus.ARADDR_M0 = 32'h0000_1000;
        step();
        n_cmp++; if ({grant, slv_sel, ar_phase, busy} !== 6'b01_01_1_1)
            begin n_err++; $display("FAIL single_addr got=%b exp=010111", {grant, slv_sel, ar_phase, busy}); end
        bus.ARREADY_S0 = 1'b1;
        step();
        n_cmp++; if ({grant, ar_phase, busy} !== 4'b01_0_1)
            begin n_err++; $display("FAIL single_data got=%b exp=0101", {grant, ar_phase, busy}); end
        bus.ARVALID_M0 = 1'b0; bus.ARREADY_S0 = 1'b0;
        bus.RVALID_S0 = 1'b1; bus.RLAST_S0 = 1'b1; bus.RREADY_M0 = 1'b1;
        step();
        n_cmp++; if ({grant, slv_sel, busy} !== 5'b00_00_0)
            begin n_err++; $display("FAIL single_done got=%b exp=00000", {grant, slv_sel, busy}); end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.ARVALID_M0 = 1'b1; bus.ARADDR_M0 = 32'h0001_0000;
        bus.ARVALID_M1 = 1'b1; bus.ARADDR_M1 = 32'h0000_0040;
        step();
        n_cmp++; if ({grant, slv_sel} !== 4'b01_10)
            begin n_err++; $display("FAIL b2b_first got=%b exp=0110", {grant, slv_sel}); end
        bus.ARREADY_S1 = 1'b1;
        step();
        bus.ARREADY_S1 = 1'b0;
        bus.RVALID_S1 = 1'b1; bus.RLAST_S1 = 1'b1; bus.RREADY_M0 = 1'b1;
        step();
        n_cmp++; if ({grant, slv_sel, ar_phase, busy} !== 6'b10_01_1_1)
            begin n_err++; $display("FAIL b2b_second got=%b exp=100111", {grant, slv_sel, ar_phase, busy}); end
        clear_inputs();
    endtask

    task automatic test_burst();
        do_reset();
        bus.ARVALID_M0 = 1'b1; bus.ARADDR_M0 = 32'h0000_1000;
        step();
        bus.ARREADY_S0 = 1'b1;
        step();
        bus.ARVALID_M0 = 1'b0; bus.ARREADY_S0 = 1'b0;
        bus.RVALID_S0 = 1'b1; bus.RREADY_M0 = 1'b1;
        step();
        n_cmp++; if ({ar_phase, busy} !== 2'b01)
            begin n_err++; $display("FAIL burst_beat1 got=%b exp=01", {ar_phase, busy}); end
        // Stall beat 2 while the unselected slave/master look like a final beat.
        bus.RREADY_M0 = 1'b0;
        bus.RVALID_S1 = 1'b1; bus.RLAST_S1 = 1'b1; bus.RREADY_M1 = 1'b1;
        step();
        n_cmp++; if ({grant, ar_phase, busy} !== 4'b01_0_1)
            begin n_err++; $display("FAIL burst_stall got=%b exp=0101", {grant, ar_phase, busy}); end
        bus.RVALID_S1 = 1'b0; bus.RLAST_S1 = 1'b0; bus.RREADY_M1 = 1'b0;
        bus.RREADY_M0 = 1'b1;
        step();
        step();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL burst_beat3 got=%b exp=1", busy); end
        bus.RLAST_S0 = 1'b1;
        step();
        n_cmp++; if ({grant, busy} !== 3'b00_0)
            begin n_err++; $display("FAIL burst_last got=%b exp=000", {grant, busy}); end
        clear_inputs();
    endtask

    task automatic test_dec_err();
        do_reset();
        bus.ARVALID_M1 = 1'b1; bus.ARADDR_M1 = 32'h0002_0000;
        step();
        n_cmp++; if ({dec_err, grant, busy} !== 5'b10_00_0)
            begin n_err++; $display("FAIL dec_m1 got=%b exp=10000", {dec_err, grant, busy}); end
        bus.ARVALID_M0 = 1'b1; bus.ARADDR_M0 = 32'h0001_FFFF;
        step();
        n_cmp++; if ({dec_err, grant, slv_sel} !== 6'b10_01_10)
            begin n_err++; $display("FAIL dec_edge got=%b exp=100110", {dec_err, grant, slv_sel}); end
        // Withdraw before the address handshake: back to IDLE, pointer kept.
        clear_inputs();
        step();
        n_cmp++; if ({dec_err, grant, busy} !== 5'b00_00_0)
            begin n_err++; $display("FAIL dec_abort got=%b exp=00000", {dec_err, grant, busy}); end
        bus.ARVALID_M0 = 1'b1; bus.ARVALID_M1 = 1'b1;
        step();
        n_cmp++; if (grant !== 2'b01) begin n_err++; $display("FAIL abort_tie got=%b exp=01", grant); end
        clear_inputs();
    endtask

    task automatic test_no_final_beat();
        do_reset();
        bus.ARVALID_M1 = 1'b1; bus.ARADDR_M1 = 32'h0000_0000;
        step();
        bus.ARREADY_S0 = 1'b1;
        step();
        bus.ARVALID_M1 = 1'b0; bus.ARREADY_S0 = 1'b0;
        bus.RVALID_S0 = 1'b1; bus.RREADY_M1 = 1'b1;
`ifdef AXI_RD_WDT_EN
        begin
            int seen = 0;
            for (int i = 0; i < 30 && seen == 0; i++) begin
                step();
                if (wdt_timeout === 1'b1) seen = i + 1;
            end
            n_cmp++; if (seen == 0) begin n_err++; $display("FAIL wdt_pulse got=none exp=pulse"); end
            step();
            n_cmp++; if ({grant, wdt_timeout} !== 3'b00_0)
                begin n_err++; $display("FAIL wdt_release got=%b exp=000", {grant, wdt_timeout}); end
        end
`else
        for (int i = 0; i < 20; i++) step();
        n_cmp++; if ({grant, busy, wdt_timeout} !== 4'b10_1_0)
            begin n_err++; $display("FAIL nowdt_hold got=%b exp=1010", {grant, busy, wdt_timeout}); end
`endif
        clear_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        m0_full_read();
        bus.ARVALID_M0 = 1'b1; bus.ARADDR_M0 = 32'h0000_1000;
        step();
        bus.ARREADY_S0 = 1'b1;
        step();
        bus.ARVALID_M0 = 1'b0; bus.ARREADY_S0 = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({grant, slv_sel, ar_phase, busy, dec_err, wdt_timeout} !== 9'b0)
            begin n_err++; $display("FAIL async_reset got=%b exp=000000000",
                                    {grant, slv_sel, ar_phase, busy, dec_err, wdt_timeout}); end
        clear_inputs();
        #2;
        rst_n = 1'b1;
        bus.ARVALID_M0 = 1'b1; bus.ARVALID_M1 = 1'b1;
        step();
        n_cmp++; if (grant !== 2'b01) begin n_err++; $display("FAIL post_reset_tie got=%b exp=01", grant); end
        clear_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b1;
        clear_inputs();
        test_reset();
        test_single_grant();
        test_back_to_back();
        test_burst();
        test_dec_err();
        test_no_final_beat();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_rd_sched.md
AXI_RD_SCHED -- requirements
Module: axi_rd_sched

Interface
REQ-001 Parameter: WDT_LIMIT, 8'd255, max DATA-phase cycles before forced release (used only with AXI_RD_WDT_EN).
REQ-002 One clock; reset is asynchronous and active-low: ACLK  in  1  clock; ARESETn  in  1  async active-low reset.
REQ-003 ARVALID_M0  in  1  M0 read-address valid; ARADDR_M0  in  32  M0 read address.
REQ-004 ARVALID_M1  in  1  M1 read-address valid; ARADDR_M1  in  32  M1 read address.
REQ-005 ARREADY_S0 / ARREADY_S1  in  1 each  slave read-address ready.
REQ-006 RVALID_S0 / RVALID_S1, RLAST_S0 / RLAST_S1  in  1 each  slave read-data valid / last beat.
REQ-007 RREADY_M0 / RREADY_M1  in  1 each  master read-data ready.
REQ-008 GRANT  out  2  one-hot granted master ([0]=M0, [1]=M1), 2'b00 when none.
REQ-009 SLV_SEL  out  2  one-hot selected slave ([0]=S0, [1]=S1), 2'b00 when none.
REQ-010 AR_PHASE  out  1  high only in ADDR state; BUSY  out  1  high in ADDR or DATA.
REQ-011 DEC_ERR  out  2  per-master flag, out-of-range request seen last cycle.
REQ-012 WDT_TIMEOUT  out  1  one-cycle pulse on watchdog release.

Function
REQ-013 States IDLE, ADDR, DATA; all outputs SHALL be driven from registered state only (no input-to-output paths).
REQ-014 In-range request: ARVALID_Mx high and ARADDR_Mx[31:17]==15'b0; slave = ARADDR_Mx[16] (0->S0, 1->S1).
REQ-015 IDLE: any in-range request -> ADDR next cycle; granted master and slave bit latched on that edge (1-cycle grant latency).
REQ-016 Both requesting simultaneously: grant the master not recorded as last_grant (round-robin).
REQ-017 ADDR: ARVALID_Mg && ARREADY_Ssel -> DATA; ARVALID_Mg deasserted before handshake -> IDLE, last_grant unchanged.
REQ-018 DATA: RVALID_Ssel && RREADY_Mg && RLAST_Ssel -> last_grant := g; then ADDR (re-arbitrated, zero idle cycles) if any in-range request, else IDLE.
REQ-019 Non-final beats (RLAST low) SHALL hold state; inputs of the non-selected slave/master SHALL be ignored.
REQ-020 DEC_ERR[x] SHALL register (ARVALID_Mx && ARADDR_Mx[31:17]!=0) every cycle; such requests are never granted.

Reset
REQ-021 Asserting ARESETn low, including mid-transaction, SHALL immediately force IDLE, GRANT=00, SLV_SEL=00, AR_PHASE=0, BUSY=0, DEC_ERR=00, WDT_TIMEOUT=0, watchdog counter 0, last_grant=M1 (M0 wins first tie).

Configuration
REQ-022 Macro AXI_RD_WDT_EN defined: 8-bit counter clears on DATA entry, increments each DATA cycle; when it equals WDT_LIMIT without final beat, next state IDLE, WDT_TIMEOUT pulses one cycle, last_grant := g.
REQ-023 AXI_RD_WDT_EN undefined: no counter logic; WDT_TIMEOUT port present and tied 0; DATA waits indefinitely.

Structure
REQ-024 Shared package axi_pkg SHALL hold the state enum, master index constants, decode mask (ADDR[31:17]==0) and slave select bit position (16).
REQ-025 Sub-module rr_arb2: two-requester round-robin pick given last_grant; pointer register stays in axi_rd_sched.

Verification
REQ-026 Reset then ARVALID_M0=1, ARADDR_M0=32'h0000_1000 at cycle 0 -> cycle 1 GRANT=01, SLV_SEL=01, AR_PHASE=1.
REQ-027 Both valid in IDLE, M0 addr 32'h0001_0000, M1 addr 32'h0000_0040 -> M0 granted (SLV_SEL=10); after its RLAST handshake, M1 granted next cycle with SLV_SEL=01, no IDLE cycle.
REQ-028 ARLEN=3 burst, RREADY_M0 low on beat 2 -> state held in DATA until 4th beat with RLAST handshake, then BUSY=0.
REQ-029 ARVALID_M1=1, ARADDR_M1=32'h0002_0000 -> DEC_ERR=10 next cycle, GRANT stays 00.
REQ-030 WDT_LIMIT=8'd10, AXI_RD_WDT_EN defined, slave never asserts RLAST -> WDT_TIMEOUT pulse after 10 DATA cycles, then GRANT=00; undefined -> GRANT held.
REQ-031 ARESETn pulsed low during DATA -> all outputs reset asynchronously; next M0/M1 tie grants M0.
